// File: rtl/bitcnt_pkg.sv
// bitcnt_pkg: shared types and constants for the byte bit-count arbiter.
package bitcnt_pkg;
    localparam int BYTE_W = 8;
    localparam int CNT_W  = $clog2(BYTE_W + 1);
    typedef enum logic [1:0] {IDLE, BUSY, RESULT} state_t;
    typedef logic req_id_t;
endpackage

// File: rtl/byte_bitcnt.sv
// byte_bitcnt: combinational ones/zeros count of one byte.
module byte_bitcnt
    import bitcnt_pkg::*;
(
    input  logic [BYTE_W-1:0] data_i,
    output logic [CNT_W-1:0]  ones_o,
    output logic [CNT_W-1:0]  zeros_o
);
    always_comb begin
        ones_o = '0;
        for (int i = 0; i < BYTE_W; i++) ones_o = ones_o + CNT_W'(data_i[i]);
        zeros_o = CNT_W'(BYTE_W) - ones_o;
    end
endmodule

// File: rtl/bitcnt_arbiter.sv
// bitcnt_arbiter: round-robin share of one byte bit counter between two burst requesters.
// Define BITCNT_BYTECNT_EN to add the res_bytes output (bytes in the reported burst).
module bitcnt_arbiter
    import bitcnt_pkg::*;
#(
    parameter int BURST_LEN = 16,
    parameter int ACC_W     = 8
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             req0_valid,
    input  logic [7:0]       req0_data,
    input  logic             req0_last,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [7:0]       req1_data,
    input  logic             req1_last,
    output logic             req1_ready,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             res_id,
    output logic [ACC_W-1:0] res_ones,
    output logic [ACC_W-1:0] res_zeros
`ifdef BITCNT_BYTECNT_EN
    ,
    output logic [$clog2(BURST_LEN+1)-1:0] res_bytes
`endif
);
    localparam int BC_W = $clog2(BURST_LEN + 1);

    if (2**ACC_W <= 8*BURST_LEN) begin : g_acc_w_check
        $error("ACC_W too narrow to hold a full burst count");
    end

    state_t            state_q, state_d;
    req_id_t           grant_q, grant_d, rr_q, rr_d;
    logic              served_q, served_d;
    logic [ACC_W-1:0]  ones_q, ones_d, zeros_q, zeros_d;
    logic [BC_W-1:0]   cnt_q, cnt_d;
    logic [BYTE_W-1:0] sel_data;
    logic [CNT_W-1:0]  byte_ones, byte_zeros;
    logic              sel_valid, sel_last;

    assign sel_valid = grant_q ? req1_valid : req0_valid;
    assign sel_data  = grant_q ? req1_data  : req0_data;
    assign sel_last  = grant_q ? req1_last  : req0_last;

    byte_bitcnt u_bitcnt (
        .data_i  (sel_data),
        .ones_o  (byte_ones),
        .zeros_o (byte_zeros)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q  <= IDLE;
            grant_q  <= 1'b0;
            rr_q     <= 1'b0;
            served_q <= 1'b0;
            ones_q   <= '0;
            zeros_q  <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_q     <= rr_d;
            served_q <= served_d;
            ones_q   <= ones_d;
            zeros_q  <= zeros_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_d     = rr_q;
        served_d = served_q;
        ones_d   = ones_q;
        zeros_d  = zeros_q;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE: if (req0_valid || req1_valid) begin
                state_d = BUSY;
                // No burst has finished since reset -> no previous owner, so req0 takes the tie.
                grant_d = (req0_valid && req1_valid) ? (served_q & ~rr_q) : req1_valid;
            end
            BUSY: if (sel_valid) begin
                ones_d  = ones_q + ACC_W'(byte_ones);
                zeros_d = zeros_q + ACC_W'(byte_zeros);
                cnt_d   = cnt_q + BC_W'(1);
                state_d = (sel_last || cnt_d == BC_W'(BURST_LEN)) ? RESULT : BUSY;
            end
            RESULT: if (res_ready) begin
                state_d  = IDLE;
                ones_d   = '0;
                zeros_d  = '0;
                cnt_d    = '0;
                rr_d     = grant_q;
                served_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    assign req0_ready = (state_q == BUSY) && !grant_q;
    assign req1_ready = (state_q == BUSY) && grant_q;
    assign res_valid  = state_q == RESULT;
    assign res_id     = grant_q;
    assign res_ones   = ones_q;
    assign res_zeros  = zeros_q;
`ifdef BITCNT_BYTECNT_EN
    assign res_bytes  = cnt_q;
`endif
endmodule

// File: tb/tb_bitcnt_arbiter.sv
// tb_bitcnt_arbiter: directed and randomized checks of bitcnt_arbiter against a burst-level scoreboard.
module tb_bitcnt_arbiter;
    localparam int BURST = 16;

    typedef struct { logic [7:0] d; logic l; int gap; } beat_t;
    typedef struct { int id; int ones; int zeros; } res_t;

    logic       clk = 0, n_rst = 0, res_ready = 0;
    logic [1:0] v = 0, l = 0;
    logic [7:0] d [2];
    logic       req0_ready, req1_ready, res_valid, res_id;
    logic [7:0] res_ones, res_zeros;

    beat_t q0[$], q1[$];
    beat_t cur [2];
    bit    have [2];
    res_t  exq[$], res_log[$], last_r;
    int    owner = -1, op_n = 0, op_ones = 0, op_zeros = 0;
    int    n_chk = 0, n_fail = 0, n_res = 0, rmode = 1;
    bit    due = 0, bubble = 0, bubble_chk = 0;

    bitcnt_arbiter dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .req0_valid (v[0]),
        .req0_data  (d[0]),
        .req0_last  (l[0]),
        .req0_ready (req0_ready),
        .req1_valid (v[1]),
        .req1_data  (d[1]),
        .req1_last  (l[1]),
        .req1_ready (req1_ready),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_id     (res_id),
        .res_ones   (res_ones),
        .res_zeros  (res_zeros)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic push(input int r, input logic [7:0] dd, input logic ll, input int g);
        beat_t b;
        b.d = dd; b.l = ll; b.gap = g;
        if (r != 0) q1.push_back(b); else q0.push_back(b);
    endtask

    function automatic int qsize(input int r);
        return (r != 0) ? q1.size() : q0.size();
    endfunction

    task automatic tick();
        @(posedge clk); #2;
    endtask

    task automatic flush_model();
        q0.delete(); q1.delete(); exq.delete();
        have[0] = 0; have[1] = 0;
        owner = -1; op_n = 0; op_ones = 0; op_zeros = 0;
        due = 0; bubble = 0; bubble_chk = 0;
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        while (k < budget && !(q0.size() == 0 && q1.size() == 0 && !have[0] && !have[1] &&
                               op_n == 0 && exq.size() == 0 && !res_valid)) begin
            tick(); k++;
        end
        if (k == budget) chk("idle_timeout", 1, 0);
    endtask

    // Requester drivers, result sink and burst-level scoreboard, one cycle per pass.
    initial begin
        d[0] = 0; d[1] = 0;
        forever begin
            @(negedge clk);
            res_ready = (rmode == 1) || (rmode == 2 && $urandom_range(0, 9) < 7);
            if (due) begin chk("latency", res_valid, 1); due = 0; end
            if (res_valid) begin
                chk("ready_in_result", {req0_ready, req1_ready}, 0);
                if (exq.size() == 0) chk("spurious_result", 1, 0);
                else begin
                    chk("res_id", res_id, exq[0].id);
                    chk("res_ones", res_ones, exq[0].ones);
                    chk("res_zeros", res_zeros, exq[0].zeros);
                    if (res_ready) begin
                        last_r = exq.pop_front();
                        res_log.push_back(last_r);
                        n_res++;
                        bubble = 1;
                    end
                end
            end
            for (int r = 0; r < 2; r++) begin
                if (!have[r] && qsize(r) > 0) begin
                    cur[r] = (r != 0) ? q1.pop_front() : q0.pop_front();
                    have[r] = 1;
                end
                if (have[r] && cur[r].gap > 0) begin
                    cur[r].gap--;
                    v[r] = 0;
                end else begin
                    v[r] = have[r];
                    if (have[r]) begin d[r] = cur[r].d; l[r] = cur[r].l; end
                end
            end
            #4;
            chk("ready_excl", req0_ready & req1_ready, 0);
            if (bubble_chk) begin chk("idle_bubble", {req0_ready, req1_ready}, 0); bubble_chk = 0; end
            if (bubble) begin bubble = 0; bubble_chk = 1; end
            for (int r = 0; r < 2; r++) begin
                if (v[r] && ((r != 0) ? req1_ready : req0_ready)) begin
                    have[r] = 0;
                    if (owner < 0) owner = r; else chk("owner", r, owner);
                    op_n++;
                    op_ones += $countones(d[r]);
                    op_zeros += $countones(~d[r]);
                    if (l[r] || op_n == BURST) begin
                        exq.push_back('{owner, op_ones, op_zeros});
                        owner = -1; op_n = 0; op_ones = 0; op_zeros = 0;
                        due = 1;
                    end
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n0, ord, k, len;
        bit forced;
        repeat (3) tick();
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_id", res_id, 0);
        chk("rst_res_ones", res_ones, 0);
        chk("rst_res_zeros", res_zeros, 0);
        chk("rst_readys", {req0_ready, req1_ready}, 0);

        // Tie straight out of reset: req0, req1, req0.
        push(0, 8'h01, 0, 0); push(0, 8'h03, 1, 0); push(0, 8'h07, 1, 0);
        push(1, 8'hF0, 1, 0);
        tick(); n_rst = 1;
        wait_idle(300);
        chk("tie_count", res_log.size(), 3);
        ord = 0;
        foreach (res_log[i]) ord = ord * 2 + res_log[i].id;
        chk("tie_order", ord, 3'b010);

        push(0, 8'hA5, 0, 0); push(0, 8'hFF, 0, 0); push(0, 8'h00, 1, 0);
        wait_idle(200);
        chk("t1_id", last_r.id, 0);
        chk("t1_ones", last_r.ones, 12);
        chk("t1_zeros", last_r.zeros, 12);

        n0 = n_res;
        for (int i = 0; i < 16; i++) push(1, 8'h01, 0, 0);
        wait_idle(300);
        chk("forced_count", n_res - n0, 1);
        chk("forced_id", last_r.id, 1);
        chk("forced_ones", last_r.ones, 16);
        chk("forced_zeros", last_r.zeros, 112);

        // Result held back by res_ready while req1 waits.
        rmode = 0;
        push(0, 8'h0F, 1, 0); push(1, 8'h3C, 1, 0);
        k = 0;
        while (k < 50 && !res_valid) begin tick(); k++; end
        if (k == 50) chk("hold_timeout", 1, 0);
        repeat (5) begin
            tick();
            chk("hold_valid", res_valid, 1);
            chk("hold_id", res_id, 0);
            chk("hold_ones", res_ones, 4);
            chk("hold_zeros", res_zeros, 4);
            chk("hold_readys", {req0_ready, req1_ready}, 0);
        end
        rmode = 1;
        wait_idle(200);
        chk("hold_next_id", last_r.id, 1);
        chk("hold_next_ones", last_r.ones, 4);

        // Owner drops valid mid-burst; req1 must stay blocked.
        res_log.delete();
        push(0, 8'h33, 0, 0); push(0, 8'h77, 0, 3); push(0, 8'h80, 1, 0);
        push(1, 8'hAA, 1, 0);
        wait_idle(300);
        chk("gap_count", res_log.size(), 2);
        if (res_log.size() == 2) begin
            chk("gap_id0", res_log[0].id, 0);
            chk("gap_ones", res_log[0].ones, 11);
            chk("gap_zeros", res_log[0].zeros, 13);
            chk("gap_id1", res_log[1].id, 1);
        end

        // Leave req0 as last owner, then reset mid-burst.
        push(0, 8'h01, 1, 0);
        wait_idle(200);
        for (int i = 0; i < 4; i++) push(0, 8'hFF, 0, 0);
        k = 0;
        while (k < 100 && op_n < 2) begin tick(); k++; end
        if (k == 100) chk("rst_mid_timeout", 1, 0);
        n_rst = 0;
        #1;
        flush_model();
        chk("mid_rst_valid", res_valid, 0);
        chk("mid_rst_ones", res_ones, 0);
        chk("mid_rst_zeros", res_zeros, 0);
        chk("mid_rst_readys", {req0_ready, req1_ready}, 0);
        res_log.delete();
        push(0, 8'h02, 1, 0); push(1, 8'h04, 1, 0);
        tick(); tick();
        n_rst = 1;
        wait_idle(200);
        chk("post_rst_count", res_log.size(), 2);
        if (res_log.size() == 2) chk("post_rst_tie", res_log[0].id, 0);

        // Random bursts with valid gaps and random result back-pressure.
        rmode = 2;
        n0 = n_res;
        for (int b = 0; b < 40; b++) begin
            k = $urandom_range(0, 1);
            len = $urandom_range(1, 16);
            forced = (len == 16) && ($urandom_range(0, 1) == 1);
            for (int i = 0; i < len; i++)
                push(k, 8'($urandom), (i == len - 1) && !forced,
                     ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);
        end
        wait_idle(20000);
        chk("rand_count", n_res - n0, 40);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
